// File: rtl/tag_nios_system_sram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port 32-bit on-chip SRAM.
// Grants one Avalon-MM master per cycle, returns reads one cycle later and flags out-of-range accesses.
module tag_nios_system_sram_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int BE_W      = DATA_W / 8,
    parameter int NUM_WORDS = 12288
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,

    output logic              range_err
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_WORDS);

    logic req_0, req_1;
    logic sel;          // 1 selects master 1; idle cycles fall back to master 0
    logic accepted;
    logic sel_read, sel_write;
    logic in_range;
    logic acc_read;

    logic last_grant;
    logic rv_valid, rv_owner, rv_oor;
    logic range_err_q;

    assign req_0 = m0_read | m0_write;
    assign req_1 = m1_read | m1_write;

    // Under contention the master that was not served last wins.
    assign sel      = req_1 & (~req_0 | ~last_grant);
    assign accepted = ~reset & (req_0 | req_1);

    assign m0_waitrequest = reset | (req_0 & sel);
    assign m1_waitrequest = reset | (req_1 & ~sel);

    assign ram_address    = sel ? m1_address    : m0_address;
    assign ram_byteenable = sel ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = sel ? m1_writedata  : m0_writedata;
    assign sel_read       = sel ? m1_read       : m0_read;
    assign sel_write      = sel ? m1_write      : m0_write;

    assign in_range = {1'b0, ram_address} < LIMIT;
    // A simultaneous read+write is a write and produces no response.
    assign acc_read = accepted & sel_read & ~sel_write;

    assign ram_chipselect = accepted & in_range;
    assign ram_write      = accepted & sel_write & in_range;
    assign ram_clken      = 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= 1'b1;
            rv_valid    <= 1'b0;
            rv_owner    <= 1'b0;
            rv_oor      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            if (accepted) begin
                last_grant <= sel;
            end
            rv_valid <= acc_read;
            rv_owner <= sel;
            rv_oor   <= ~in_range;
            if (accepted & ~in_range) begin
                range_err_q <= 1'b1;
            end
        end
    end

    // Gating with reset drops a read that was accepted just before reset asserted.
    assign m0_readdatavalid = rv_valid & ~rv_owner & ~reset;
    assign m1_readdatavalid = rv_valid &  rv_owner & ~reset;

    assign m0_readdata = (m0_readdatavalid & ~rv_oor) ? ram_readdata : '0;
    assign m1_readdata = (m1_readdatavalid & ~rv_oor) ? ram_readdata : '0;

    assign range_err = range_err_q;

endmodule

// File: tb/tb_tag_nios_system_sram_arbiter.sv
// Self-checking bench: per-cycle vector table for handshake/RAM strobes, scoreboard queues for read data.
module tb_tag_nios_system_sram_arbiter;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } mst_t;

    typedef struct {
        logic rst;
        mst_t m0;
        mst_t m1;
        logic ew0;
        logic ew1;
        logic ecs;
        logic ewe;
        logic ere;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [13:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;
    logic        range_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram_mem [0:16383];
    logic [31:0] shadow  [0:16383];
    vec_t        vecs[$];
    exp_t        sbq[2][$];

    always #5 clk = ~clk;

    tag_nios_system_sram_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .ram_address      (ram_address),
        .ram_byteenable   (ram_byteenable),
        .ram_chipselect   (ram_chipselect),
        .ram_write        (ram_write),
        .ram_writedata    (ram_writedata),
        .ram_clken        (ram_clken),
        .ram_readdata     (ram_readdata),
        .range_err        (range_err)
    );

    // SRAM model: byte-enabled write, registered read (1-cycle latency).
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) ram_mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
                end
            end
            ram_readdata <= ram_mem[ram_address];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mst_t mst(input logic rd, input logic wr, input logic [13:0] addr,
                                 input logic [3:0] be, input logic [31:0] data);
        mst_t m;
        m.rd = rd; m.wr = wr; m.addr = addr; m.be = be; m.data = data;
        return m;
    endfunction

    task automatic add(input logic rst, input mst_t a, input mst_t b, input logic ew0,
                       input logic ew1, input logic ecs, input logic ewe, input logic ere);
        vec_t v;
        v.rst = rst; v.m0 = a; v.m1 = b;
        v.ew0 = ew0; v.ew1 = ew1; v.ecs = ecs; v.ewe = ewe; v.ere = ere;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        m0_read       = v.m0.rd;   m0_write      = v.m0.wr;
        m0_address    = v.m0.addr; m0_byteenable = v.m0.be;
        m0_writedata  = v.m0.data;
        m1_read       = v.m1.rd;   m1_write      = v.m1.wr;
        m1_address    = v.m1.addr; m1_byteenable = v.m1.be;
        m1_writedata  = v.m1.data;
    endtask

    task automatic sb_one(input int m, input int k, input logic rst, input logic vld,
                          input logic [31:0] rdata);
        string nm;
        nm = (m == 0) ? "m0" : "m1";
        if (rst) begin
            check({nm, "_rdv_in_reset"}, vld, 0);
            check({nm, "_rdata_in_reset"}, rdata, 0);
            sbq[m].delete();
        end else if (vld) begin
            if (sbq[m].size() == 0 || sbq[m][0].due != k) begin
                check({nm, "_rdv_spurious"}, vld, 0);
            end else begin
                check({nm, "_rdata"}, rdata, sbq[m][0].data);
                void'(sbq[m].pop_front());
            end
        end else begin
            check({nm, "_rdata_idle_zero"}, rdata, 0);
            if (sbq[m].size() != 0 && sbq[m][0].due <= k) begin
                check({nm, "_rdv_missing"}, vld, 1);
                void'(sbq[m].pop_front());
            end
        end
    endtask

    initial begin
        mst_t idle, c0, c1, w;
        vec_t v;

        for (int i = 0; i < 16384; i++) begin
            ram_mem[i] = '0;
            shadow[i]  = '0;
        end
        ram_mem[1] = 32'h1111_1111;     shadow[1] = 32'h1111_1111;
        ram_mem[2] = 32'h2222_2222;     shadow[2] = 32'h2222_2222;
        ram_mem[12287] = 32'hCAFE_F00D; shadow[12287] = 32'hCAFE_F00D;
        ram_readdata = '0;

        idle = mst(0, 0, 14'h0, 4'h0, 32'h0);
        c0   = mst(1, 0, 14'h0001, 4'hF, 32'h0);
        c1   = mst(1, 0, 14'h0002, 4'hF, 32'h0);

        //  rst  m0                                          m1                                           w0 w1 cs we re
        add(1, idle,                                         idle,                                        1, 1, 0, 0, 0); // 0
        add(1, mst(1, 0, 14'h0010, 4'hF, 0),                 idle,                                        1, 1, 0, 0, 0); // 1
        add(0, idle,                                         idle,                                        0, 0, 0, 0, 0); // 2
        add(0, mst(0, 1, 14'h0010, 4'hF, 32'hDEAD_BEEF),     idle,                                        0, 0, 1, 1, 0); // 3
        add(0, mst(1, 0, 14'h0010, 4'hF, 0),                 idle,                                        0, 0, 1, 0, 0); // 4
        add(0, idle,                                         idle,                                        0, 0, 0, 0, 0); // 5
        add(1, idle,                                         idle,                                        1, 1, 0, 0, 0); // 6
        add(0, c0, c1,                                                                                    0, 1, 1, 0, 0); // 7
        add(0, c0, c1,                                                                                    1, 0, 1, 0, 0); // 8
        add(0, c0, c1,                                                                                    0, 1, 1, 0, 0); // 9
        add(0, c0, c1,                                                                                    1, 0, 1, 0, 0); // 10
        add(0, c0, c1,                                                                                    0, 1, 1, 0, 0); // 11
        add(0, c0, c1,                                                                                    1, 0, 1, 0, 0); // 12
        add(0, idle,                                         idle,                                        0, 0, 0, 0, 0); // 13
        add(0, idle,                                         mst(0, 1, 14'h0020, 4'b0101, 32'hAABB_CCDD), 0, 0, 1, 1, 0); // 14
        add(0, mst(1, 0, 14'h0020, 4'hF, 0),                 idle,                                        0, 0, 1, 0, 0); // 15
        add(0, idle,                                         idle,                                        0, 0, 0, 0, 0); // 16
        add(0, mst(1, 0, 14'h0010, 4'hF, 0),                 idle,                                        0, 0, 1, 0, 0); // 17
        add(1, idle,                                         idle,                                        1, 1, 0, 0, 0); // 18
        add(0, idle,                                         idle,                                        0, 0, 0, 0, 0); // 19
        add(0, idle,                                         mst(0, 1, 14'h3000, 4'hF, 32'h1234_5678),    0, 0, 0, 0, 0); // 20
        add(0, idle,                                         mst(1, 0, 14'h3FFF, 4'hF, 0),                0, 0, 0, 0, 1); // 21
        add(0, idle,                                         idle,                                        0, 0, 0, 0, 1); // 22
        add(0, idle,                                         mst(1, 1, 14'h0005, 4'hF, 32'h0000_0005),    0, 0, 1, 1, 1); // 23
        add(0, mst(1, 0, 14'h0005, 4'hF, 0),                 idle,                                        0, 0, 1, 0, 1); // 24
        add(0, idle,                                         mst(1, 0, 14'h2FFF, 4'hF, 0),                0, 0, 1, 0, 1); // 25
        add(0, idle,                                         idle,                                        0, 0, 0, 0, 1); // 26
        add(1, idle,                                         idle,                                        1, 1, 0, 0, 0); // 27
        add(0, idle,                                         idle,                                        0, 0, 0, 0, 0); // 28

        v = vecs[0];
        drive(v);

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            @(posedge clk);
            #1;
            drive(v);
            @(negedge clk);
            check($sformatf("v%0d_m0_waitrequest", k), m0_waitrequest, v.ew0);
            check($sformatf("v%0d_m1_waitrequest", k), m1_waitrequest, v.ew1);
            check($sformatf("v%0d_ram_chipselect", k), ram_chipselect, v.ecs);
            check($sformatf("v%0d_ram_write", k), ram_write, v.ewe);
            if (!v.rst) check($sformatf("v%0d_range_err", k), range_err, v.ere);
            sb_one(0, k, v.rst, m0_readdatavalid, m0_readdata);
            sb_one(1, k, v.rst, m1_readdatavalid, m1_readdata);
            if (!v.rst) begin
                if (v.m0.rd && !v.m0.wr && !v.ew0)
                    sbq[0].push_back('{(v.m0.addr < 14'd12288) ? shadow[v.m0.addr] : 32'h0, k + 1});
                if (v.m1.rd && !v.m1.wr && !v.ew1)
                    sbq[1].push_back('{(v.m1.addr < 14'd12288) ? shadow[v.m1.addr] : 32'h0, k + 1});
                if (v.ewe) begin
                    w = (v.m0.wr && !v.ew0) ? v.m0 : v.m1;
                    for (int b = 0; b < 4; b++) begin
                        if (w.be[b]) shadow[w.addr][b*8 +: 8] = w.data[b*8 +: 8];
                    end
                end
            end
        end

        // Drain: one idle cycle, then no read may be left outstanding.
        @(posedge clk);
        #1;
        drive(vecs[vecs.size() - 1]);
        @(negedge clk);
        sb_one(0, vecs.size(), 1'b0, m0_readdatavalid, m0_readdata);
        sb_one(1, vecs.size(), 1'b0, m1_readdatavalid, m1_readdata);
        check("m0_outstanding", sbq[0].size(), 0);
        check("m1_outstanding", sbq[1].size(), 0);
        check("ram_byteenable_merge", ram_mem[32], 32'h00BB_00DD);
        check("oor_write_suppressed", ram_mem[12288], 32'h0);
        check("rw_as_write", ram_mem[5], 32'h0000_0005);
        check("ram_clken", ram_clken, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
